coherence_bus_arbiter: RTL and testbench
========================================

// Module: coherence_bus_arbiter
// PURPOSE
//  Shares the single coherence bus between N_CPU cache controllers. Picks one pending
//  CPU-side miss/invalidate at a time with round-robin priority and broadcasts it to
//  all bus-side snoop FSMs. Waits for any snooper writeback, sequences the memory
//  access, then returns a done pulse. Sits between per-CPU cache FSMs and directory/memory.
// PARAMETERS
//  N_CPU    4  number of requesting cache controllers (>=2)
//  ADDR_W   8  block address width
//  MEM_LAT  4  memory access cycles for readMiss/writeMiss (>=1)
// PORTS
//  clk             in   1              rising-edge clock
//  reset           in   1              synchronous, active-high reset
//  req             in   N_CPU          per-CPU request, held until done
//  req_msg         in   2*N_CPU        per-CPU message: 01 readMiss, 10 invalidate, 11 writeMiss, 00 none
//  req_addr        in   ADDR_W*N_CPU   per-CPU block address
//  grant           out  N_CPU          one-hot owner of the bus, BCAST..DONE
//  bus_readMiss    out  1              1-cycle broadcast strobe
//  bus_invalidate  out  1              1-cycle broadcast strobe
//  bus_writeMiss   out  1              1-cycle broadcast strobe
//  bus_addr        out  ADDR_W         address of current transaction
//  bus_src         out  $clog2(N_CPU)  index of current requester
//  snoop_wb        in   N_CPU          snooper writeback needed; sampled in BCAST
//  wb_done         in   1              memory accepted snooper writeback
//  done            out  N_CPU          1-cycle completion pulse to granted CPU
//  busy            out  1              high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; grant, strobes, bus_addr, bus_src, done, busy = 0; rr_ptr = N_CPU-1.
//  All outputs are registered.
//  Eligible CPU i: req[i]=1 and req_msg[i]!=00. A request with msg 00 is ignored.
//  States:
//  - IDLE: if any CPU is eligible, choose the first eligible index after rr_ptr (wrapping).
//    Latch idx, msg and addr, then go to BCAST.
//  - BCAST (1 cycle):
//    - grant[idx]=1; exactly one strobe matching msg; bus_addr/bus_src valid.
//    - wbreq = |(snoop_wb & ~onehot(idx)); the requester's own bit is masked.
//    - msg=invalidate: go to DONE; snoop_wb is ignored.
//    - else if wbreq: go to WB_WAIT.
//    - else: go to MEM with cnt=MEM_LAT-1.
//  - WB_WAIT: hold until wb_done=1, then go to MEM with cnt=MEM_LAT-1. No timeout.
//  - MEM: at cnt==0 go to DONE, else decrement cnt. Occupies exactly MEM_LAT cycles.
//  - DONE (1 cycle): done[idx]=1; rr_ptr<=idx; next state IDLE. grant drops on exit.
//  Latency from IDLE cycle C that selects the request (no writeback):
//  - readMiss/writeMiss: BCAST at C+1, done at C+2+MEM_LAT.
//  - invalidate: done at C+2.
//  - writeback adds the WB_WAIT cycles, including the cycle wb_done is seen.
//  Requests and input changes:
//  - A requester must drop req the cycle after done. If req is still high in IDLE, it is
//    a new request, arbitrated behind the others.
//  - req/req_msg/req_addr changes after latching are ignored. The transaction completes
//    and done still pulses even if req falls.
//  - New requests arriving while busy wait; no queueing beyond the req levels.
//  - Simultaneous requests are served strictly round-robin. No CPU waits more than N_CPU-1
//    transactions.
//  Reset mid-transaction: next cycle is IDLE with all outputs 0. No done pulse for the
//  aborted transaction; rr_ptr returns to N_CPU-1.
//  Strobes are mutually exclusive; at most one grant bit and at most one done bit per cycle.
// TESTING
//  1 CPU1 readMiss addr 0x3C, snoop_wb=0, MEM_LAT=4 -> bus_readMiss, bus_addr=0x3C, bus_src=1
//    in cycle C+1; done[1] only in C+6.
//  2 After reset, all 4 CPUs request readMiss and hold req -> grant order 0,1,2,3,0;
//    each done one cycle wide.
//  3 CPU2 writeMiss, snoop_wb=0001 in BCAST, wb_done at BCAST+3 -> stays in WB_WAIT until
//    wb_done, then 4 MEM cycles, then done[2].
//  4 CPU3 invalidate with snoop_wb=1111 -> bus_invalidate at C+1, done[3] at C+2,
//    no WB_WAIT/MEM.
//  5 reset during MEM of CPU1's transaction -> all outputs 0 next cycle, no done[1];
//    then CPUs 1 and 2 request -> CPU1 granted first.
//  6 CPU0 req with msg 00 -> never granted; CPU0 writeMiss with snoop_wb=0001 ->
//    own bit masked, goes straight to MEM.

Source files
------------

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner of the shared coherence bus: broadcasts one CPU miss/invalidate,
// waits out any snooper writeback, sequences memory, then pulses done to the owner.
module coherence_bus_arbiter #(
  parameter int N_CPU   = 4,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 4,
  localparam int IW = (N_CPU > 1) ? $clog2(N_CPU) : 1,
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CPU-1:0]        req,
  input  logic [2*N_CPU-1:0]      req_msg,
  input  logic [ADDR_W*N_CPU-1:0] req_addr,
  output logic [N_CPU-1:0]        grant,
  output logic                    bus_readMiss,
  output logic                    bus_invalidate,
  output logic                    bus_writeMiss,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [IW-1:0]           bus_src,
  input  logic [N_CPU-1:0]        snoop_wb,
  input  logic                    wb_done,
  output logic [N_CPU-1:0]        done,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, BCAST, WB_WAIT, MEM, DONE} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n, rr_ptr, rr_n;
  logic [1:0]        msg, msg_n;
  logic [ADDR_W-1:0] addr_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_CPU-1:0]  onehot_n;
  logic              wbreq;

  logic              sel_vld;
  logic [IW-1:0]     sel_idx;
  logic [1:0]        sel_msg;
  logic [ADDR_W-1:0] sel_addr;
  int                j;

  // First eligible requester strictly after rr_ptr, wrapping around.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_msg  = 2'b00;
    sel_addr = '0;
    j        = 0;
    for (int k = 1; k <= N_CPU; k++) begin
      j = (int'(rr_ptr) + k) % N_CPU;
      if (!sel_vld && req[j] && req_msg[2*j +: 2] != 2'b00) begin
        sel_vld  = 1'b1;
        sel_idx  = IW'(j);
        sel_msg  = req_msg[2*j +: 2];
        sel_addr = req_addr[ADDR_W*j +: ADDR_W];
      end
    end
  end

  // The requester never writes back to itself, so its own snoop bit is masked.
  assign wbreq = |(snoop_wb & ~(N_CPU'(1) << idx));

  always_comb begin
    state_n = state;
    idx_n   = idx;
    msg_n   = msg;
    addr_n  = bus_addr;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    case (state)
      IDLE: if (sel_vld) begin
        state_n = BCAST;
        idx_n   = sel_idx;
        msg_n   = sel_msg;
        addr_n  = sel_addr;
      end
      BCAST: begin
        if (msg == 2'b10) state_n = DONE;
        else if (wbreq)   state_n = WB_WAIT;
        else begin
          state_n = MEM;
          cnt_n   = CW'(MEM_LAT - 1);
        end
      end
      WB_WAIT: if (wb_done) begin
        state_n = MEM;
        cnt_n   = CW'(MEM_LAT - 1);
      end
      MEM: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CW'(1);
      end
      DONE: begin
        state_n = IDLE;
        rr_n    = idx;
      end
      default: state_n = IDLE;
    endcase
  end

  assign onehot_n = N_CPU'(1) << idx_n;

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      msg            <= 2'b00;
      cnt            <= '0;
      rr_ptr         <= IW'(N_CPU - 1);
      grant          <= '0;
      bus_readMiss   <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_writeMiss  <= 1'b0;
      bus_addr       <= '0;
      bus_src        <= '0;
      done           <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      msg            <= msg_n;
      cnt            <= cnt_n;
      rr_ptr         <= rr_n;
      grant          <= (state_n != IDLE) ? onehot_n : '0;
      bus_readMiss   <= (state_n == BCAST) && (msg_n == 2'b01);
      bus_invalidate <= (state_n == BCAST) && (msg_n == 2'b10);
      bus_writeMiss  <= (state_n == BCAST) && (msg_n == 2'b11);
      bus_addr       <= addr_n;
      bus_src        <= idx_n;
      done           <= (state_n == DONE) ? onehot_n : '0;
      busy           <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized bench: a transaction-level model predicts broadcast and done events with
// their cycles; a monitor pops and compares them as the DUT shows them.
module tb_coherence_bus_arbiter;
  localparam int N = 4, AW = 8, ML = 4, NCYC = 4000;

  logic          clk, reset;
  logic [N-1:0]  req, grant, snoop_wb, done;
  logic [2*N-1:0] req_msg;
  logic [AW*N-1:0] req_addr;
  logic          bus_readMiss, bus_invalidate, bus_writeMiss, wb_done, busy;
  logic [AW-1:0] bus_addr;
  logic [1:0]    bus_src;

  coherence_bus_arbiter #(.N_CPU(N), .ADDR_W(AW), .MEM_LAT(ML)) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg), .req_addr(req_addr),
    .grant(grant), .bus_readMiss(bus_readMiss), .bus_invalidate(bus_invalidate),
    .bus_writeMiss(bus_writeMiss), .bus_addr(bus_addr), .bus_src(bus_src),
    .snoop_wb(snoop_wb), .wb_done(wb_done), .done(done), .busy(busy));

  typedef struct {int cyc; bit dn; int src; logic [1:0] msg; logic [AW-1:0] addr;} ev_t;
  ev_t q[$];

  int cyc = 0, nc = 0, nf = 0;
  int busy_lo = 1, busy_hi = 0, busy_src = 0, rst_chk = 3;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    nc++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [20:0] pack_exp(ev_t e);
    logic [N-1:0] oh;
    logic [2:0] st;
    oh = N'(1) << e.src;
    st = e.dn ? 3'b000 : {e.msg == 2'b01, e.msg == 2'b10, e.msg == 2'b11};
    return {oh, st, e.addr, 2'(e.src), e.dn ? oh : N'(0)};
  endfunction

  // Monitor
  initial forever begin
    @(negedge clk);
    if (cyc >= 3) begin
      logic eb;
      logic [20:0] got;
      ev_t e;
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy_grant", {busy, grant}, {eb, eb ? N'(1) << busy_src : N'(0)});
      if (cyc == rst_chk) chk("reset_zero", {bus_addr, bus_src}, '0);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk(e.dn ? "done_missing" : "bcast_missing", 64'(e.cyc), 64'(-1));
      end
      got = {grant, bus_readMiss, bus_invalidate, bus_writeMiss, bus_addr, bus_src, done};
      if (bus_readMiss || bus_invalidate || bus_writeMiss || |done) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          chk(e.dn ? "done_event" : "bcast_event", 64'(got), 64'(pack_exp(e)));
        end else chk("unexpected_event", 64'(got), 64'(0));
      end
    end
  end

  // Requesters, snoop/memory environment and reference model
  bit   served[N];
  int   done_of[N], age[N];
  int   rr = N - 1, free_cyc = 3, bc_cyc = -1, wbd_cyc = -1;
  int   win_lo = 1, win_hi = 0, mem_lo = 1, mem_hi = 0, rst_cnt = 0;
  logic [N-1:0] sv;

  task automatic raise(int i);
    req[i] = 1'b1;
    req_msg[2*i +: 2] = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    req_addr[AW*i +: AW] = AW'($urandom);
    age[i] = 0;
  endtask

  initial begin
    reset = 1; req = '0; req_msg = '0; req_addr = '0; snoop_wb = '0; wb_done = 0;
    repeat (3) @(posedge clk);
    #1;
    while (cyc < NCYC) begin
      int n;
      n = cyc;
      reset = 0;
      for (int i = 0; i < N; i++) begin
        if (served[i]) begin
          if (n == done_of[i] + 1) begin
            served[i] = 0;
            if ($urandom_range(0, 3) == 0) raise(i);
            else req[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            req_msg[2*i +: 2] = 2'($urandom);
            req_addr[AW*i +: AW] = AW'($urandom);
            req[i] = 1'($urandom);
          end
        end else if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) raise(i);
        end else if (req_msg[2*i +: 2] == 2'b00) begin
          age[i]++;
          if (age[i] > 20) req[i] = 1'b0;
        end
      end
      if (rst_cnt < 4 && n >= mem_lo && n <= mem_hi && $urandom_range(0, 7) == 0) begin
        // Abort mid-memory: pending events after this cycle vanish.
        reset = 1; rst_cnt++; req = '0;
        for (int i = 0; i < N; i++) served[i] = 0;
        while (q.size() > 0 && q[$].cyc > n) void'(q.pop_back());
        if (busy_hi > n) busy_hi = n;
        if (win_hi > n) win_hi = n;
        mem_hi = 0; mem_lo = 1; bc_cyc = -1; wbd_cyc = -1;
        free_cyc = n + 1; rr = N - 1; rst_chk = n + 1;
      end else if (n >= free_cyc) begin
        int sel;
        sel = -1;
        for (int k = 1; k <= N && sel < 0; k++) begin
          int c;
          c = (rr + k) % N;
          if (req[c] && req_msg[2*c +: 2] != 2'b00) sel = c;
        end
        if (sel >= 0) begin
          ev_t e;
          int d, dn;
          e.src = sel; e.msg = req_msg[2*sel +: 2]; e.addr = req_addr[AW*sel +: AW];
          sv = ($urandom_range(0, 1) == 0) ? N'(0) : N'($urandom);
          bc_cyc = n + 1;
          wbd_cyc = -1;
          if (e.msg == 2'b10) dn = n + 2;
          else if ((sv & ~(N'(1) << sel)) != 0) begin
            d = $urandom_range(1, 4);
            wbd_cyc = n + 1 + d;
            dn = n + 2 + d + ML;
          end else dn = n + 2 + ML;
          e.cyc = n + 1; e.dn = 0; q.push_back(e);
          e.cyc = dn;    e.dn = 1; q.push_back(e);
          if (e.msg != 2'b10) begin mem_lo = dn - ML; mem_hi = dn - 1; end
          busy_lo = n + 1; busy_hi = dn; busy_src = sel;
          win_lo = n; win_hi = dn;
          served[sel] = 1; done_of[sel] = dn;
          rr = sel; free_cyc = dn + 1;
        end
      end
      snoop_wb = (n == bc_cyc) ? sv : N'($urandom);
      wb_done = (n == wbd_cyc) ? 1'b1 : (n >= win_lo && n <= win_hi) ? 1'b0 : 1'($urandom);
      @(posedge clk);
      #1;
    end
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    while (q.size() > 0 && q[0].cyc < cyc - 1) begin
      ev_t e;
      e = q.pop_front();
      chk("event_never_seen", 64'(e.cyc), 64'(-1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
